gmii_rx_deframer: RTL



---
 rtl/gmii_rx_deframer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks FCS, length and RX_ER,
// and streams the frame bytes with end-of-frame status. All outputs registered.
module gmii_rx_deframer #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518,
  parameter bit          STRIP_FCS = 1'b1
) (
  input  logic       rx_clk,
  input  logic       rst_n,
  input  logic       rx_dv,
  input  logic [7:0] rxd,
  input  logic       rx_er,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_err,
  output logic       frame_ok,
  output logic       frame_bad,
  output logic       crc_err
);

  // Holding back the last 4 bytes lets the FCS be dropped without knowing the
  // frame length in advance.
  localparam int unsigned Depth  = STRIP_FCS ? 5 : 1;
  localparam int unsigned LineW  = Depth * 8;
  localparam int unsigned CntW   = $clog2(MAX_FRAME + 2);
  localparam logic [CntW-1:0] CntSat = CntW'(MAX_FRAME + 1);
  localparam logic [31:0] CrcPoly    = 32'hEDB88320;
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StPreamble,
    StData,
    StDrop
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [LineW-1:0] line_q, line_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       merr_q, merr_d;
  logic       ok_q, ok_d;
  logic       bad_q, bad_d;
  logic       crcerr_q, crcerr_d;

  logic       line_full;
  logic       crc_bad;
  logic       frame_err;

  // One byte of reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic [7:0]  d;
    logic        fb;
    c = crc;
    d = data;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[0];
      c  = {1'b0, c[31:1]} ^ ({32{fb}} & CrcPoly);
      d  = {1'b0, d[7:1]};
    end
    return c;
  endfunction

  // The count saturates above Depth, so it doubles as the delay-line fill level.
  assign line_full = (cnt_q >= CntW'(Depth));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    line_d    = line_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    merr_d    = 1'b0;
    ok_d      = 1'b0;
    bad_d     = 1'b0;
    crcerr_d  = 1'b0;
    crc_bad   = (crc_q != CrcResidue);
    frame_err = crc_bad | err_q | (cnt_q < CntW'(MIN_FRAME)) | (cnt_q > CntW'(MAX_FRAME));

    unique case (state_q)
      StWaitIdle: begin
        if (!rx_dv) state_d = StIdle;
      end
      StIdle: begin
        // RX_DV=0 with RX_ER=1 is false carrier and is ignored here.
        if (rx_dv) state_d = (rxd == 8'h55 && !rx_er) ? StPreamble : StDrop;
      end
      StPreamble: begin
        if (!rx_dv) begin
          bad_d   = 1'b1;
          state_d = StIdle;
        end else if (rx_er) begin
          state_d = StDrop;
        end else if (rxd == 8'hD5) begin
          state_d = StData;
          crc_d   = 32'hFFFF_FFFF;
          cnt_d   = '0;
          err_d   = 1'b0;
          line_d  = '0;
        end else if (rxd != 8'h55) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (!rx_dv) begin
          bad_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StData: begin
        if (rx_dv) begin
          crc_d  = crc_byte(crc_q, rxd);
          if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
          err_d  = err_q | rx_er;
          line_d = LineW'({line_q, rxd});
          if (line_full) begin
            valid_d = 1'b1;
            data_d  = line_q[LineW-1 -: 8];
          end
        end else begin
          // End of frame: flush the oldest byte as the last beat, discard the rest.
          if (line_full) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            data_d  = line_q[LineW-1 -: 8];
            merr_d  = frame_err;
          end
          ok_d     = line_full & ~frame_err;
          bad_d    = ~(line_full & ~frame_err);
          crcerr_d = crc_bad;
          line_d   = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StWaitIdle;
      crc_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      line_q   <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      merr_q   <= 1'b0;
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;
      crcerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      line_q   <= line_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      merr_q   <= merr_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
      crcerr_q <= crcerr_d;
    end
  end

  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_last    = last_q;
  assign m_err     = merr_q;
  assign frame_ok  = ok_q;
  assign frame_bad = bad_q;
  assign crc_err   = crcerr_q;

endmodule
